apb_mem_slave: RTL and testbench



---
 rtl/apb_mem_slave.sv | 152 +++++++++++++++
 tb/tb_apb_mem_slave.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB completer that maps one psel line onto the single-port
// memory bus. Adds programmable wait states, optional mready stalling, and
// pslverr for addresses at or beyond DEPTH.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a setup phase on psel[ID]
// SETUP  | setup-phase cycle; address/data/direction captured here
// ACCESS | strobe issued on the first cycle; waiting for completion
// DONE   | single cycle with pready=1
module apb_mem_slave #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int NSEL        = 4,
    parameter int ID          = 1,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSEL-1:0]   psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              use_sub_ready,
    output logic              mce,
    output logic              mrden,
    output logic              mwren,
    output logic [ADDR_W-1:0] maddr,
    output logic [DATA_W-1:0] mwdata,
    input  logic [DATA_W-1:0] mrdata,
    input  logic              mready
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  WAIT_L  = CNT_W'(WAIT_CYCLES);
    // One extra bit so DEPTH == 2^ADDR_W is representable and never flags an error.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              first_q;
    logic              write_q;
    logic              err_q;
    logic [DATA_W-1:0] prdata_q;
    logic              pready_q, pslverr_q;
    logic              mce_q, mrden_q, mwren_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] mwdata_q;

    logic sel;
    logic addr_err;
    logic complete;

    assign sel      = psel[ID];
    assign addr_err = ({1'b0, paddr} >= DEPTH_L);
    // Error transfers never touch the sub-module, so its ready is not consulted.
    assign complete = (cnt_q == '0) && !first_q && (err_q || !use_sub_ready || mready);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; a falling select aborts ACCESS without completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel && !penable) state_d = SETUP;
            SETUP: begin
                if (!sel)         state_d = IDLE;
                else if (penable) state_d = ACCESS;
            end
            ACCESS: begin
                if (!sel)          state_d = IDLE;
                else if (complete) state_d = DONE;
            end
            DONE:    state_d = (sel && !penable) ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, transfer capture and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            first_q   <= 1'b0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            mce_q     <= 1'b0;
            mrden_q   <= 1'b0;
            mwren_q   <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            mce_q     <= 1'b0;
            mrden_q   <= 1'b0;
            mwren_q   <= 1'b0;

            if (state_q == SETUP) begin
                maddr_q  <= paddr;
                mwdata_q <= pwdata;
                write_q  <= pwrite;
                err_q    <= addr_err;
            end

            if (state_q == SETUP && state_d == ACCESS) begin
                first_q <= 1'b1;
                cnt_q   <= WAIT_L;
                if (!addr_err) begin
                    mce_q   <= 1'b1;
                    mwren_q <= pwrite;
                    mrden_q <= !pwrite;
                end
            end

            // The first ACCESS cycle only arms the counter; it counts from the second.
            if (state_q == ACCESS) begin
                if (first_q)             first_q <= 1'b0;
                else if (cnt_q != '0)    cnt_q   <= cnt_q - CNT_W'(1);
            end

            if (state_q == ACCESS && state_d == DONE) begin
                pready_q  <= 1'b1;
                pslverr_q <= err_q;
                if (!err_q && !write_q) prdata_q <= mrdata;
            end
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign mce     = mce_q;
    assign mrden   = mrden_q;
    assign mwren   = mwren_q;
    assign maddr   = maddr_q;
    assign mwdata  = mwdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three completers on one APB bus (IDs 1, 2, 3)
// with different wait-state and depth settings, each backed by a simple
// synchronous memory model.
module tb_apb_mem_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] psel = '0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = '0;
    logic [7:0] pwdata = '0;
    logic       use_sub_ready = 1'b0;
    logic       mready = 1'b0;

    logic [7:0] prdata_a [3];
    logic       pready_a [3];
    logic       pslverr_a[3];
    logic       mce_a    [3];
    logic       mrden_a  [3];
    logic       mwren_a  [3];
    logic [7:0] maddr_a  [3];
    logic [7:0] mwdata_a [3];
    logic [7:0] mrdata_a [3];

    logic [7:0] mem [3][256];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .NSEL(4), .ID(1), .WAIT_CYCLES(0)) u_d0 (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[0]), .pready(pready_a[0]),
        .pslverr(pslverr_a[0]), .use_sub_ready(use_sub_ready), .mce(mce_a[0]),
        .mrden(mrden_a[0]), .mwren(mwren_a[0]), .maddr(maddr_a[0]), .mwdata(mwdata_a[0]),
        .mrdata(mrdata_a[0]), .mready(mready));

    apb_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .NSEL(4), .ID(2), .WAIT_CYCLES(3)) u_d1 (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[1]), .pready(pready_a[1]),
        .pslverr(pslverr_a[1]), .use_sub_ready(use_sub_ready), .mce(mce_a[1]),
        .mrden(mrden_a[1]), .mwren(mwren_a[1]), .maddr(maddr_a[1]), .mwdata(mwdata_a[1]),
        .mrdata(mrdata_a[1]), .mready(mready));

    apb_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .NSEL(4), .ID(3), .WAIT_CYCLES(0)) u_d2 (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[2]), .pready(pready_a[2]),
        .pslverr(pslverr_a[2]), .use_sub_ready(use_sub_ready), .mce(mce_a[2]),
        .mrden(mrden_a[2]), .mwren(mwren_a[2]), .maddr(maddr_a[2]), .mwdata(mwdata_a[2]),
        .mrdata(mrdata_a[2]), .mready(mready));

    // Memory models: synchronous, read data valid the cycle after mrden
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (reset) begin
                for (int a = 0; a < 256; a++) mem[g][a] <= 8'h00;
                mrdata_a[g] <= 8'h00;
            end else if (mce_a[g]) begin
                if (mwren_a[g]) mem[g][maddr_a[g]] <= mwdata_a[g];
                if (mrden_a[g]) mrdata_a[g] <= mem[g][maddr_a[g]];
            end
        end
        if (reset) begin
            mem[0][3]     <= 8'h33;
            mem[0][4]     <= 8'h44;
            mem[2][8'h20] <= 8'h3C;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One complete transfer on completer d; returns observed cycle counts and results.
    task automatic xfer(input int d, input bit wr, input int addr, input int wdata,
                        input bit sub, input int stall,
                        output int lat, output int rd, output int err,
                        output int mces, output int mwrens);
        lat = -1; rd = -1; err = -1; mces = 0; mwrens = 0;
        use_sub_ready = sub;
        mready  = (stall == 0);
        psel    = 4'(1) << (d + 1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = 8'(addr);
        pwdata  = 8'(wdata);
        @(negedge clk);
        penable = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (mce_a[d])   mces++;
            if (mwren_a[d]) mwrens++;
            mready = (n > stall);
            if (pready_a[d]) begin
                lat = n;
                rd  = int'(prdata_a[d]);
                err = int'(pslverr_a[d]);
                break;
            end
        end
        psel    = '0;
        penable = 1'b0;
    endtask

    typedef struct {
        int d; bit wr; int addr; int wdata; bit sub; int stall;
        int lat; int rd; int err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int lat, rd, err, mces, mwrens;
        int t1, r1, r2, seen;

        vecs[0]  = '{0, 1'b1, 6,     'h05, 1'b0, 0, 3, 'h00, 0};
        vecs[1]  = '{0, 1'b0, 6,     'h00, 1'b0, 0, 3, 'h05, 0};
        vecs[2]  = '{0, 1'b1, 5,     'h04, 1'b1, 5, 7, 'h05, 0};
        vecs[3]  = '{0, 1'b0, 5,     'h00, 1'b1, 5, 7, 'h04, 0};
        vecs[4]  = '{1, 1'b1, 3,     'h02, 1'b0, 0, 6, 'h00, 0};
        vecs[5]  = '{1, 1'b0, 3,     'h00, 1'b1, 0, 6, 'h02, 0};
        vecs[6]  = '{2, 1'b1, 2,     'h77, 1'b0, 0, 3, 'h00, 0};
        vecs[7]  = '{2, 1'b0, 2,     'h00, 1'b0, 0, 3, 'h77, 0};
        vecs[8]  = '{2, 1'b1, 'h20,  'h99, 1'b1, 5, 3, 'h77, 1};
        vecs[9]  = '{2, 1'b0, 'h10,  'h00, 1'b0, 0, 3, 'h77, 1};
        vecs[10] = '{2, 1'b0, 'h0F,  'h00, 1'b0, 0, 3, 'h00, 0};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_pready_d%0d", d), int'(pready_a[d]), 0);
            chk($sformatf("reset_prdata_d%0d", d), int'(prdata_a[d]), 0);
            chk($sformatf("reset_strobes_d%0d", d),
                int'({mce_a[d], mrden_a[d], mwren_a[d], pslverr_a[d]}), 0);
            chk($sformatf("reset_maddr_mwdata_d%0d", d), int'({maddr_a[d], mwdata_a[d]}), 0);
        end

        for (int i = 0; i < 11; i++) begin
            xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].sub,
                 vecs[i].stall, lat, rd, err, mces, mwrens);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_prdata", i), rd, vecs[i].rd);
            chk($sformatf("vec%0d_pslverr", i), err, vecs[i].err);
            chk($sformatf("vec%0d_mce_pulses", i), mces, vecs[i].err ? 0 : 1);
            chk($sformatf("vec%0d_mwren_pulses", i), mwrens, (vecs[i].wr && !vecs[i].err) ? 1 : 0);
            @(negedge clk);
            chk($sformatf("vec%0d_pready_one_cycle", i), int'(pready_a[vecs[i].d]), 0);
        end
        chk("err_write_mem_unchanged", int'(mem[2][8'h20]), 'h3C);
        chk("d1_mem_addr3", int'(mem[1][3]), 'h02);

        // Select line not owned by any completer
        use_sub_ready = 1'b0;
        seen = 0;
        psel = 4'b0001; penable = 1'b0; paddr = 8'd6; pwrite = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (pready_a[d] || mce_a[d]) seen++;
        end
        chk("foreign_psel_no_response", seen, 0);
        psel = '0; penable = 1'b0;
        @(negedge clk);

        // penable without a preceding setup phase
        seen = 0;
        psel = 4'b0010; penable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (pready_a[0] || mce_a[0]) seen++;
        end
        chk("penable_without_setup_ignored", seen, 0);
        psel = '0; penable = 1'b0;
        @(negedge clk);

        // Back-to-back reads on completer 0
        t1 = -1; r1 = -1; r2 = -1; lat = -1;
        psel = 4'b0010; penable = 1'b0; pwrite = 1'b0; paddr = 8'd3;
        @(negedge clk);
        penable = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (pready_a[0]) begin t1 = cyc; r1 = int'(prdata_a[0]); break; end
        end
        penable = 1'b0; paddr = 8'd4;
        @(negedge clk);
        penable = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (pready_a[0]) begin lat = cyc - t1; r2 = int'(prdata_a[0]); break; end
        end
        psel = '0; penable = 1'b0;
        chk("b2b_first_prdata", r1, 'h33);
        chk("b2b_second_prdata", r2, 'h44);
        chk("b2b_done_spacing", (t1 < 0) ? -1 : lat, 4);
        @(negedge clk);

        // Abort: select drops in the first ACCESS cycle
        seen = 0;
        psel = 4'b0010; penable = 1'b0; pwrite = 1'b0; paddr = 8'd6;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        chk("abort_strobe_issued", int'(mrden_a[0]), 1);
        psel = '0; penable = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (pready_a[0]) seen++;
        end
        chk("abort_no_pready", seen, 0);
        chk("abort_prdata_held", int'(prdata_a[0]), 'h44);
        xfer(0, 1'b0, 6, 0, 1'b0, 0, lat, rd, err, mces, mwrens);
        chk("after_abort_latency", lat, 3);
        chk("after_abort_prdata", rd, 'h05);
        @(negedge clk);

        // Reset mid-ACCESS on a write
        seen = 0;
        psel = 4'b0010; penable = 1'b0; pwrite = 1'b1; paddr = 8'd9; pwdata = 8'hAB;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        chk("pre_reset_mwren", int'(mwren_a[0]), 1);
        reset = 1'b1;
        #1;
        chk("async_reset_strobes", int'({mce_a[0], mwren_a[0], mrden_a[0], pready_a[0]}), 0);
        chk("async_reset_maddr_mwdata", int'({maddr_a[0], mwdata_a[0]}), 0);
        chk("async_reset_prdata", int'(prdata_a[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (pready_a[0]) seen++;
        end
        chk("reset_no_completion", seen, 0);
        psel = '0; penable = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
